// File: rtl/arbiter_request_queue_if.sv
// arbiter_request_queue_if
// Bundles every handshake and arbiter-facing signal of arbiter_request_queue.
//   in_valid/in_ready/in_data      : per-requestor enqueue handshake
//   request/grant_oh/update_lru    : exchange with the round-robin arbiter
//   out_valid/out_ready/out_data   : single registered output port
//   out_requestor                  : source index of the transaction in out_data
// Modport slave is the queue itself; modport master is the surrounding logic
// (requestors, arbiter and downstream consumer).
interface arbiter_request_queue_if #(
    parameter int NUM_REQUESTORS = 4,
    parameter int DATA_WIDTH     = 32
);
    localparam int IDX_W = $clog2(NUM_REQUESTORS);

    logic [NUM_REQUESTORS-1:0]            in_valid;
    logic [NUM_REQUESTORS-1:0]            in_ready;
    logic [NUM_REQUESTORS*DATA_WIDTH-1:0] in_data;
    logic [NUM_REQUESTORS-1:0]            request;
    logic [NUM_REQUESTORS-1:0]            grant_oh;
    logic                                 update_lru;
    logic                                 out_valid;
    logic                                 out_ready;
    logic [DATA_WIDTH-1:0]                out_data;
    logic [IDX_W-1:0]                     out_requestor;

    modport slave (
        input  in_valid, in_data, grant_oh, out_ready,
        output in_ready, request, update_lru, out_valid, out_data, out_requestor
    );

    modport master (
        output in_valid, in_data, grant_oh, out_ready,
        input  in_ready, request, update_lru, out_valid, out_data, out_requestor
    );
endinterface

// File: rtl/arbiter_request_queue.sv
// arbiter_request_queue
// Per-requestor FIFOs feeding a shared round-robin arbiter. The queue raises a
// request for every non-empty FIFO whenever the output register can take a new
// transaction, pops the FIFO named by the arbiter's one-hot grant in the same
// cycle, and loads the popped entry into a single registered output port.
// Ports:
//   clk      : clock, all state on the rising edge
//   reset_n  : asynchronous active-low reset, empties all FIFOs and the output
//   bus      : arbiter_request_queue_if.slave (enqueue, arbiter and output signals)
module arbiter_request_queue #(
    parameter int NUM_REQUESTORS = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int FIFO_DEPTH     = 2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    arbiter_request_queue_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_REQUESTORS);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] mem   [NUM_REQUESTORS][FIFO_DEPTH];
    logic [PTR_W-1:0]      head  [NUM_REQUESTORS];
    logic [PTR_W-1:0]      tail  [NUM_REQUESTORS];
    logic [CNT_W-1:0]      count [NUM_REQUESTORS];

    logic                      out_valid_q;
    logic [DATA_WIDTH-1:0]     out_data_q;
    logic [IDX_W-1:0]          out_req_q;

    logic                      can_load;
    logic [NUM_REQUESTORS-1:0] in_ready;
    logic [NUM_REQUESTORS-1:0] request;
    logic [NUM_REQUESTORS-1:0] push;
    logic [NUM_REQUESTORS-1:0] pop;
    logic [IDX_W-1:0]          grant_idx;
    logic [DATA_WIDTH-1:0]     load_data;

    // in_ready looks only at the registered count, so a pop in the same cycle
    // never lets a full FIFO accept; this keeps in_ready free of the arbiter path.
    always_comb begin
        can_load  = !out_valid_q || bus.out_ready;
        in_ready  = '0;
        request   = '0;
        push      = '0;
        grant_idx = '0;
        for (int i = 0; i < NUM_REQUESTORS; i++) begin
            in_ready[i] = (count[i] != FULL_CNT);
            request[i]  = (count[i] != '0) && can_load;
            push[i]     = bus.in_valid[i] && in_ready[i];
        end
        // Masking with request drops any grant the arbiter gives to an idle bit.
        pop = bus.grant_oh & request;
        for (int i = 0; i < NUM_REQUESTORS; i++) begin
            if (pop[i]) begin
                grant_idx = IDX_W'(i);
            end
        end
        load_data = mem[grant_idx][head[grant_idx]];
    end

    assign bus.in_ready      = in_ready;
    assign bus.request       = request;
    assign bus.update_lru    = |request;
    assign bus.out_valid     = out_valid_q;
    assign bus.out_data      = out_data_q;
    assign bus.out_requestor = out_req_q;

    // Storage carries no reset; emptiness is tracked by count alone.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQUESTORS; i++) begin
            if (push[i]) begin
                mem[i][tail[i]] <= bus.in_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REQUESTORS; i++) begin
                head[i]  <= '0;
                tail[i]  <= '0;
                count[i] <= '0;
            end
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_req_q   <= '0;
        end else begin
            for (int i = 0; i < NUM_REQUESTORS; i++) begin
                if (push[i]) begin
                    tail[i] <= tail[i] + 1'b1;
                end
                if (pop[i]) begin
                    head[i] <= head[i] + 1'b1;
                end
                case ({push[i], pop[i]})
                    2'b10:   count[i] <= count[i] + 1'b1;
                    2'b01:   count[i] <= count[i] - 1'b1;
                    default: count[i] <= count[i];
                endcase
            end
            // A new load wins over the accept, so back-to-back transfers keep
            // out_valid high and sustain one transaction per cycle.
            if (|pop) begin
                out_valid_q <= 1'b1;
                out_data_q  <= load_data;
                out_req_q   <= grant_idx;
            end else if (out_valid_q && bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    a_grant_onehot: assert property (@(posedge clk) disable iff (!reset_n)
        (|request) |-> $onehot(bus.grant_oh));
    a_grant_idle: assert property (@(posedge clk) disable iff (!reset_n)
        (request == '0) |-> (bus.grant_oh == '0));
    a_grant_masked: assert property (@(posedge clk) disable iff (!reset_n)
        (bus.grant_oh & ~request) == '0);
endmodule

// File: tb/tb_arbiter_request_queue.sv
// tb_arbiter_request_queue
// Directed and random stimulus for arbiter_request_queue. A round-robin arbiter
// lives in the bench; expected outputs come from a queue-based reference model.
module tb_arbiter_request_queue;
    localparam int N = 4;
    localparam int W = 32;
    localparam int D = 2;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    arbiter_request_queue_if #(.NUM_REQUESTORS(N), .DATA_WIDTH(W)) bus ();

    arbiter_request_queue #(
        .NUM_REQUESTORS(N),
        .DATA_WIDTH(W),
        .FIFO_DEPTH(D)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    // Round-robin arbiter: search starts just after the last granted index.
    logic [1:0]   rr_ptr;
    logic [N-1:0] arb_grant;

    always_comb begin
        arb_grant = '0;
        for (int k = 0; k < N; k++) begin
            if (arb_grant == '0 && bus.request[(int'(rr_ptr) + k) % N]) begin
                arb_grant[(int'(rr_ptr) + k) % N] = 1'b1;
            end
        end
    end
    assign bus.grant_oh = arb_grant;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr <= '0;
        end else if (bus.update_lru) begin
            for (int k = 0; k < N; k++) begin
                if (arb_grant[k]) rr_ptr <= 2'(k + 1);
            end
        end
    end

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: one queue per requestor plus the output register.
    logic [W-1:0] mq [N][$];
    logic         mv;
    logic [W-1:0] md;
    logic [1:0]   mr;

    task automatic model_clear();
        for (int i = 0; i < N; i++) mq[i].delete();
        mv = 1'b0;
        md = '0;
        mr = '0;
    endtask

    function automatic logic [N*W-1:0] pack4(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [W-1:0] c, input logic [W-1:0] d);
        return {d, c, b, a};
    endfunction

    // Called just after a falling edge: drive, check, advance model, return at next falling edge.
    task automatic cycle(input logic [N-1:0] v, input logic [N*W-1:0] d, input logic rdy);
        logic [N-1:0] er;
        logic [N-1:0] eir;
        logic [N-1:0] g;
        logic         can;
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.out_ready = rdy;
        #1;
        can = !mv || rdy;
        for (int i = 0; i < N; i++) begin
            er[i]  = (mq[i].size() != 0) && can;
            eir[i] = (mq[i].size() < D);
        end
        chk("in_ready", bus.in_ready, eir);
        chk("request", bus.request, er);
        chk("update_lru", bus.update_lru, |er);
        chk("out_valid", bus.out_valid, mv);
        chk("out_data", bus.out_data, md);
        chk("out_requestor", bus.out_requestor, mr);
        g = bus.grant_oh & er;
        if (g != '0) begin
            for (int i = 0; i < N; i++) begin
                if (g[i]) begin
                    md = mq[i].pop_front();
                    mr = 2'(i);
                    mv = 1'b1;
                end
            end
        end else if (mv && rdy) begin
            mv = 1'b0;
        end
        for (int i = 0; i < N; i++) begin
            if (v[i] && eir[i]) mq[i].push_back(d[i*W +: W]);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        bus.in_valid  = '0;
        bus.out_ready = 1'b0;
        reset_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        model_clear();
    endtask

    task automatic rand_cycles(input int n);
        logic [N*W-1:0] d;
        for (int c = 0; c < n; c++) begin
            for (int i = 0; i < N; i++) d[i*W +: W] = $urandom;
            cycle(N'($urandom), d, ($urandom_range(0, 3) != 0));
        end
    endtask

    logic [W-1:0] seq [8];

    initial begin
        bus.in_valid  = '1;
        bus.in_data   = pack4(32'h11, 32'h22, 32'h33, 32'h44);
        bus.out_ready = 1'b1;
        model_clear();

        // Reset held with all requestors valid: nothing may enqueue.
        repeat (3) @(negedge clk);
        #1;
        chk("reset_request", bus.request, '0);
        chk("reset_update_lru", bus.update_lru, 1'b0);
        chk("reset_out_valid", bus.out_valid, 1'b0);
        reset_n = 1'b1;
        bus.in_valid = '0;
        @(negedge clk);
        #1;
        chk("post_reset_in_ready", bus.in_ready, 4'b1111);
        chk("post_reset_request", bus.request, '0);
        chk("post_reset_out_data", bus.out_data, '0);
        cycle('0, '0, 1'b1);

        // Round robin across two preloaded entries per requestor.
        apply_reset();
        for (int i = 0; i < N; i++) begin
            seq[i]     = 32'hA0 + 32'(i);
            seq[i + 4] = 32'hB0 + 32'(i);
        end
        cycle(4'hF, pack4(32'hA0, 32'hA1, 32'hA2, 32'hA3), 1'b1);
        cycle(4'hF, pack4(32'hB0, 32'hB1, 32'hB2, 32'hB3), 1'b1);
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("rr_seq_data", bus.out_data, seq[k]);
            chk("rr_seq_valid", bus.out_valid, 1'b1);
            if (k < 7) chk("rr_seq_update_lru", bus.update_lru, 1'b1);
            cycle('0, '0, 1'b1);
        end

        // Single transaction on requestor 2.
        cycle(4'b0100, pack4(32'h0, 32'h0, 32'hCAFE0002, 32'h0), 1'b1);
        #1;
        chk("single_request", bus.request, 4'b0100);
        cycle('0, '0, 1'b1);
        #1;
        chk("single_out_valid", bus.out_valid, 1'b1);
        chk("single_out_data", bus.out_data, 32'hCAFE0002);
        chk("single_out_requestor", bus.out_requestor, 2'd2);
        cycle('0, '0, 1'b1);
        #1;
        chk("single_drained", bus.out_valid, 1'b0);

        // Backpressure: output frozen, no requests, then load on the accept edge.
        cycle(4'hF, pack4(32'hC0, 32'hC1, 32'hC2, 32'hC3), 1'b0);
        repeat (3) cycle('0, '0, 1'b0);
        #1;
        chk("bp_request", bus.request, '0);
        chk("bp_update_lru", bus.update_lru, 1'b0);
        cycle('0, '0, 1'b1);
        #1;
        chk("bp_reload_valid", bus.out_valid, 1'b1);
        repeat (6) cycle('0, '0, 1'b1);

        // Full FIFO on requestor 1 while the output is stalled.
        cycle(4'b0001, pack4(32'hD0, 32'h0, 32'h0, 32'h0), 1'b0);
        cycle('0, '0, 1'b0);
        cycle(4'b0010, pack4(32'h0, 32'hE1, 32'h0, 32'h0), 1'b0);
        cycle(4'b0010, pack4(32'h0, 32'hE2, 32'h0, 32'h0), 1'b0);
        #1;
        chk("full_in_ready", bus.in_ready[1], 1'b0);
        cycle(4'b0010, pack4(32'h0, 32'hE3, 32'h0, 32'h0), 1'b0);
        cycle(4'b0010, pack4(32'h0, 32'hE4, 32'h0, 32'h0), 1'b1);
        #1;
        chk("full_reopen_in_ready", bus.in_ready[1], 1'b1);
        repeat (5) cycle('0, '0, 1'b1);

        // Randomized traffic.
        rand_cycles(400);

        // Asynchronous reset mid-transaction.
        cycle(4'b0111, pack4(32'hF0, 32'hF1, 32'hF2, 32'h0), 1'b0);
        cycle(4'b0111, pack4(32'hF4, 32'hF5, 32'hF6, 32'h0), 1'b0);
        #1;
        chk("pre_reset_out_valid", bus.out_valid, 1'b1);
        bus.in_valid = '0;
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_reset_out_valid", bus.out_valid, 1'b0);
        chk("async_reset_request", bus.request, '0);
        chk("async_reset_update_lru", bus.update_lru, 1'b0);
        chk("async_reset_out_data", bus.out_data, '0);
        model_clear();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) cycle('0, '0, 1'b1);
        rand_cycles(150);
        repeat (8) cycle('0, '0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
